// File: rtl/adc_scan_pkg.sv
// rtl/adc_scan_pkg.sv - shared state encoding and width helpers for the ADC scan averager
package adc_scan_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_CONV,
        S_WAIT_HI,
        S_WAIT_LO,
        S_SHIFT,
        S_ACC,
        S_OUT
    } scan_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Counter/index width that never collapses to zero bits.
    function automatic int wid(input int n);
        return (clog2(n) > 0) ? clog2(n) : 1;
    endfunction

    function automatic int out_width(input int vfs_mv);
        return clog2(vfs_mv + 1);
    endfunction

endpackage

// File: rtl/adc_frame_rx.sv
// rtl/adc_frame_rx.sv - serial ADC frame receiver: SCLK divider and shift register
module adc_frame_rx
    import adc_scan_pkg::*;
#(
    parameter int FRAME_BITS = 16,
    parameter int ADC_BITS   = 12,
    parameter int CLK_DIV    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                sdat,
    output logic                sclk,
    output logic                busy,
    output logic                done,
    output logic [ADC_BITS-1:0] code
);

    localparam int DIV_W = wid(CLK_DIV);
    localparam int BIT_W = clog2(FRAME_BITS + 1);

    logic [ADC_BITS-1:0] shreg;
    logic [DIV_W-1:0]    div_cnt;
    logic [BIT_W-1:0]    bit_cnt;

    // Only the trailing ADC_BITS of the frame are kept; leading bits fall off the top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            shreg   <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    busy    <= 1'b1;
                    sclk    <= 1'b0;
                    div_cnt <= '0;
                    bit_cnt <= '0;
                end
            end else if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                div_cnt <= '0;
                if (!sclk) begin
                    sclk    <= 1'b1;
                    shreg   <= {shreg[ADC_BITS-2:0], sdat};
                    bit_cnt <= bit_cnt + 1'b1;
                end else if (bit_cnt == BIT_W'(FRAME_BITS)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    sclk <= 1'b0;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    assign code = shreg;

endmodule

// File: rtl/adc_scan_avg.sv
// rtl/adc_scan_avg.sv - multi-channel ADC scanner with per-channel averaging and mV scaling
module adc_scan_avg
    import adc_scan_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int ADC_BITS   = 12,
    parameter int FRAME_BITS = 16,
    parameter int CLK_DIV    = 4,
    parameter int CONV_PW    = 2,
    parameter int SETTLE     = 8,
    parameter int BUSY_TO    = 1024,
    parameter int AVG_LOG2   = 2,
    parameter int VFS_MV     = 5000,
    localparam int CH_W      = wid(NCH),
    localparam int OUT_W     = out_width(VFS_MV)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             st,
    input  logic             cont,
    input  logic             SDAT,
    input  logic             BUSY,
    output logic             st_ADC,
    output logic             SCLK,
    output logic [CH_W-1:0]  MUX_SEL,
    output logic [OUT_W-1:0] dat,
    output logic [CH_W-1:0]  dat_ch,
    output logic             dat_vld,
    output logic             done,
    output logic             err_to
);

    localparam int ACC_W  = ADC_BITS + AVG_LOG2;
    localparam int SMP_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int TMR_W  = 16;
    localparam int TO_W   = wid(BUSY_TO);
    localparam int PROD_W = ADC_BITS + OUT_W;

    scan_state_t         state;
    logic [TMR_W-1:0]    tmr;
    logic [TO_W-1:0]     to_cnt;
    logic [1:0]          hi_cnt;
    logic [SMP_W-1:0]    smp_cnt;
    logic [ACC_W-1:0]    acc;

    logic                rx_start;
    logic                rx_busy;
    logic                rx_done;
    logic [ADC_BITS-1:0] rx_code;
    logic [ADC_BITS-1:0] mean;
    logic [PROD_W-1:0]   prod;

    assign rx_start = (state == S_WAIT_LO) && !BUSY && !rx_busy;
    assign mean     = ADC_BITS'(acc >> AVG_LOG2);
    assign prod     = PROD_W'(mean) * PROD_W'(VFS_MV);

    adc_frame_rx #(
        .FRAME_BITS (FRAME_BITS),
        .ADC_BITS   (ADC_BITS),
        .CLK_DIV    (CLK_DIV)
    ) u_rx (
        .clk   (clk),
        .rst   (rst),
        .start (rx_start),
        .sdat  (SDAT),
        .sclk  (SCLK),
        .busy  (rx_busy),
        .done  (rx_done),
        .code  (rx_code)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            tmr     <= '0;
            to_cnt  <= '0;
            hi_cnt  <= '0;
            smp_cnt <= '0;
            acc     <= '0;
            st_ADC  <= 1'b0;
            MUX_SEL <= '0;
            dat     <= '0;
            dat_ch  <= '0;
            dat_vld <= 1'b0;
            done    <= 1'b0;
            err_to  <= 1'b0;
        end else begin
            dat_vld <= 1'b0;
            done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (st) begin
                        err_to <= 1'b0;
                        tmr    <= '0;
                        state  <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (tmr == TMR_W'(SETTLE - 1)) begin
                        tmr    <= '0;
                        st_ADC <= 1'b1;
                        state  <= S_CONV;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                S_CONV: begin
                    if (tmr == TMR_W'(CONV_PW - 1)) begin
                        tmr    <= '0;
                        st_ADC <= 1'b0;
                        to_cnt <= '0;
                        hi_cnt <= '0;
                        state  <= S_WAIT_HI;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                // A converter whose BUSY pulse is too short to catch is tolerated after 4 cycles.
                S_WAIT_HI: begin
                    if (to_cnt == TO_W'(BUSY_TO - 1)) begin
                        err_to  <= 1'b1;
                        acc     <= '0;
                        smp_cnt <= '0;
                        MUX_SEL <= '0;
                        state   <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                        if (BUSY || hi_cnt == 2'd3) state  <= S_WAIT_LO;
                        else                        hi_cnt <= hi_cnt + 1'b1;
                    end
                end
                S_WAIT_LO: begin
                    if (!BUSY) begin
                        state <= S_SHIFT;
                    end else if (to_cnt == TO_W'(BUSY_TO - 1)) begin
                        err_to  <= 1'b1;
                        acc     <= '0;
                        smp_cnt <= '0;
                        MUX_SEL <= '0;
                        state   <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (rx_done) state <= S_ACC;
                end
                S_ACC: begin
                    acc <= acc + ACC_W'(rx_code);
                    if (smp_cnt == SMP_W'((1 << AVG_LOG2) - 1)) begin
                        smp_cnt <= '0;
                        state   <= S_OUT;
                    end else begin
                        smp_cnt <= smp_cnt + 1'b1;
                        tmr     <= '0;
                        st_ADC  <= 1'b1;
                        state   <= S_CONV;
                    end
                end
                S_OUT: begin
                    dat     <= OUT_W'(prod >> ADC_BITS);
                    dat_ch  <= MUX_SEL;
                    dat_vld <= 1'b1;
                    acc     <= '0;
                    tmr     <= '0;
                    if (MUX_SEL == CH_W'(NCH - 1)) begin
                        done    <= 1'b1;
                        MUX_SEL <= '0;
                        state   <= cont ? S_SETTLE : S_IDLE;
                    end else begin
                        MUX_SEL <= MUX_SEL + 1'b1;
                        state   <= S_SETTLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_scan_avg.sv
// tb/tb_adc_scan_avg.sv - scoreboard bench for adc_scan_avg with a serial ADC model
module tb_adc_scan_avg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        st = 1'b0;
    logic        cont = 1'b0;
    logic        SDAT = 1'b0;
    logic        BUSY = 1'b0;
    logic        st_ADC;
    logic        SCLK;
    logic [1:0]  MUX_SEL;
    logic [12:0] dat;
    logic [1:0]  dat_ch;
    logic        dat_vld;
    logic        done;
    logic        err_to;

    adc_scan_avg dut (
        .clk     (clk),
        .rst     (rst),
        .st      (st),
        .cont    (cont),
        .SDAT    (SDAT),
        .BUSY    (BUSY),
        .st_ADC  (st_ADC),
        .SCLK    (SCLK),
        .MUX_SEL (MUX_SEL),
        .dat     (dat),
        .dat_ch  (dat_ch),
        .dat_vld (dat_vld),
        .done    (done),
        .err_to  (err_to)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int exp_q[$];
    int done_cnt = 0;
    int vld_cnt = 0;
    int ch_code[4] = '{0, 4095, 2048, 819};
    logic ramp = 1'b0;
    logic hold_busy = 1'b0;

    task automatic chk(input string name, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // ADC model: BUSY 20 cycles after each CONVST, optionally stuck high on channel 2.
    int   busy_left = 0;
    logic sta_q = 1'b0;
    always @(negedge clk) begin
        if (rst) busy_left = 0;
        else if (st_ADC && !sta_q) busy_left = 20;
        else if (busy_left > 0) busy_left--;
        sta_q = st_ADC;
        BUSY = (hold_busy && MUX_SEL == 2'd2) ? 1'b1 : (busy_left > 0);
    end

    logic [15:0] frame = '0;
    int frame_id = 0;
    int ramp_idx = 0;
    always @(posedge st_ADC or posedge rst) begin
        if (rst) begin
            ramp_idx = 0;
        end else begin
            frame = 16'(ch_code[MUX_SEL] + (ramp ? ramp_idx : 0));
            ramp_idx = (ramp_idx + 1) % 4;
            frame_id++;
        end
    end

    int seen_id = 0;
    int bit_idx = 0;
    always @(negedge SCLK) begin
        if (seen_id != frame_id) begin
            seen_id = frame_id;
            bit_idx = 0;
        end
        SDAT = (bit_idx < 16) ? frame[15 - bit_idx] : 1'b0;
        bit_idx++;
    end

    // Monitor: pops the scoreboard on every dat_vld.
    int   conv_seen = 0;
    logic sta_m = 1'b0;
    int   e;
    always @(negedge clk) begin
        if (rst || err_to) conv_seen = 0;
        else if (st_ADC && !sta_m) conv_seen++;
        sta_m = st_ADC;
        if (done) done_cnt++;
        if (dat_vld) begin
            vld_cnt++;
            chk("convst_per_result", conv_seen, 4);
            conv_seen = 0;
            chk("dat_vld_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("dat_ch", int'(dat_ch), e >> 16);
                chk("dat", int'(dat), e & 16'hffff);
            end
        end
    end

    task automatic pulse_st();
        @(negedge clk) st = 1'b1;
        @(negedge clk) st = 1'b0;
    endtask

    task automatic push_scan(input int d0, input int d1, input int d2, input int d3);
        exp_q.push_back((0 << 16) | d0);
        exp_q.push_back((1 << 16) | d1);
        exp_q.push_back((2 << 16) | d2);
        exp_q.push_back((3 << 16) | d3);
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        chk(name, exp_q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    int d0;
    int v0;
    int rises;
    logic sclk_q;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_sclk", SCLK, 1);
        chk("rst_st_adc", st_ADC, 0);
        chk("rst_mux_sel", MUX_SEL, 0);
        chk("rst_dat", dat, 0);
        chk("rst_dat_vld", dat_vld, 0);
        chk("rst_done", done, 0);
        chk("rst_err_to", err_to, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single scan with constant codes; a stray st mid-scan must be ignored.
        push_scan(0, 4998, 2500, 999);
        d0 = done_cnt;
        pulse_st();
        repeat (300) @(negedge clk);
        pulse_st();
        wait_drain("scan1_drain", 5000);
        chk("scan1_done", done_cnt - d0, 1);
        v0 = vld_cnt;
        repeat (800) @(negedge clk);
        chk("scan1_idle_no_vld", vld_cnt - v0, 0);
        chk("scan1_idle_mux", MUX_SEL, 0);

        // Averaging: codes base..base+3 per channel, mean = base+1.
        ch_code = '{100, 200, 300, 400};
        ramp = 1'b1;
        push_scan(123, 245, 367, 489);
        d0 = done_cnt;
        pulse_st();
        wait_drain("avg_drain", 5000);
        chk("avg_done", done_cnt - d0, 1);
        ramp = 1'b0;
        ch_code = '{0, 4095, 2048, 819};

        // BUSY stuck on channel 2.
        hold_busy = 1'b1;
        exp_q.push_back((0 << 16) | 0);
        exp_q.push_back((1 << 16) | 4998);
        d0 = done_cnt;
        pulse_st();
        for (int i = 0; i < 5000 && !err_to; i++) @(negedge clk);
        chk("timeout_err_to", err_to, 1);
        chk("timeout_pending", exp_q.size(), 0);
        v0 = vld_cnt;
        repeat (100) @(negedge clk);
        chk("timeout_no_vld", vld_cnt - v0, 0);
        chk("timeout_no_done", done_cnt - d0, 0);
        chk("timeout_mux_sel", MUX_SEL, 0);
        chk("timeout_st_adc", st_ADC, 0);
        chk("timeout_sclk", SCLK, 1);
        chk("timeout_sticky", err_to, 1);
        hold_busy = 1'b0;
        push_scan(0, 4998, 2500, 999);
        d0 = done_cnt;
        pulse_st();
        chk("st_clears_err_to", err_to, 0);
        wait_drain("after_to_drain", 5000);
        chk("after_to_done", done_cnt - d0, 1);

        // Continuous scanning, cont dropped during the third scan.
        cont = 1'b1;
        push_scan(0, 4998, 2500, 999);
        push_scan(0, 4998, 2500, 999);
        push_scan(0, 4998, 2500, 999);
        d0 = done_cnt;
        pulse_st();
        for (int i = 0; i < 10000 && (done_cnt - d0) < 2; i++) @(negedge clk);
        chk("cont_two_done", done_cnt - d0, 2);
        v0 = vld_cnt;
        for (int i = 0; i < 2000 && vld_cnt == v0; i++) @(negedge clk);
        cont = 1'b0;
        wait_drain("cont_drain", 5000);
        v0 = vld_cnt;
        repeat (800) @(negedge clk);
        chk("cont_done_total", done_cnt - d0, 3);
        chk("cont_idle_no_vld", vld_cnt - v0, 0);

        // Reset in the middle of a frame, at the 7th SCLK rise.
        pulse_st();
        rises = 0;
        sclk_q = SCLK;
        for (int i = 0; i < 3000 && rises < 7; i++) begin
            @(negedge clk);
            if (SCLK && !sclk_q) rises++;
            sclk_q = SCLK;
        end
        chk("rst_mid_frame_reached", rises, 7);
        rst = 1'b1;
        #1;
        chk("midrst_sclk", SCLK, 1);
        chk("midrst_st_adc", st_ADC, 0);
        chk("midrst_mux_sel", MUX_SEL, 0);
        chk("midrst_dat", dat, 0);
        chk("midrst_dat_vld", dat_vld, 0);
        chk("midrst_err_to", err_to, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        push_scan(0, 4998, 2500, 999);
        d0 = done_cnt;
        pulse_st();
        wait_drain("post_rst_drain", 5000);
        chk("post_rst_done", done_cnt - d0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
